mic_sample_fifo: RTL and testbench

- Sits directly downstream of the SPI microphone reader.
- Generates the periodic one-cycle `sample` strobe that starts each SPI frame.
- Detects frame completion on the chip-select rising edge and pushes the 16-bit word into a circular FIFO.
- The FIFO presents first-word-fall-through data to the consumer and keeps sticky error flags.

---
 rtl/mic_sample_fifo_if.sv | 31 +++
 rtl/mic_sample_fifo.sv | 92 +++++++++
 tb/tb_mic_sample_fifo.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mic_sample_fifo_if.sv
// Bus between the microphone sample FIFO, the SPI reader and the sample consumer.
// The master drives the control, frame and pop inputs; the slave is the FIFO.
interface mic_sample_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          enable;
  logic          clear;
  logic          sample;
  logic          cs_b;
  logic [15:0]   spi_data;
  logic          rd_en;
  logic [15:0]   rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          missed_sample;

  modport master (
    output enable, clear, cs_b, spi_data, rd_en,
    input  sample, rd_data, rd_valid, full, empty, count, overflow, missed_sample
  );

  modport slave (
    input  enable, clear, cs_b, spi_data, rd_en,
    output sample, rd_data, rd_valid, full, empty, count, overflow, missed_sample
  );
endinterface

// File: rtl/mic_sample_fifo.sv
// Sample-strobe generator and FWFT circular FIFO sitting behind the SPI microphone reader.
// Frames are captured on the cs_b rising edge; overflow and missed-sample flags are sticky.
module mic_sample_fifo #(
  parameter int DEPTH      = 16,
  parameter int SAMPLE_DIV = 64
) (
  input logic              sysclk,
  input logic              PRESETn,
  mic_sample_fifo_if.slave bus
);
  localparam int             AW       = $clog2(DEPTH);
  localparam int             DW       = $clog2(SAMPLE_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] r_div_cnt;
  logic          r_sample;
  logic          r_cs_b_q;
  logic          r_overflow;
  logic          r_missed;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [15:0]   r_mem [DEPTH];

  logic w_tick;
  logic w_wr_req;
  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;

  assign w_tick   = bus.enable && (r_div_cnt == DIV_LAST);
  assign w_wr_req = bus.cs_b && !r_cs_b_q;
  assign w_full   = (r_count == CNT_FULL);
  assign w_empty  = (r_count == '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
  assign w_wr_ok  = w_wr_req && (!w_full || bus.rd_en);
  assign w_rd_ok  = bus.rd_en && !w_empty;

  always_ff @(posedge sysclk or negedge PRESETn) begin
    if (!PRESETn) begin
      r_div_cnt <= '0;
      r_sample  <= 1'b0;
      r_cs_b_q  <= 1'b1;
    end else begin
      if (!bus.enable || w_tick) r_div_cnt <= '0;
      else                       r_div_cnt <= r_div_cnt + DW'(1);
      r_sample <= w_tick && bus.cs_b;
      r_cs_b_q <= bus.cs_b;
    end
  end

  always_ff @(posedge sysclk or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_missed   <= 1'b0;
    end else if (bus.clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_missed   <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + AW'(1);
      if (w_rd_ok) r_rptr <= r_rptr + AW'(1);
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_wr_req && !w_wr_ok)    r_overflow <= 1'b1;
      if (w_tick && !bus.cs_b)     r_missed   <= 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (w_wr_ok && !bus.clear) r_mem[r_wptr] <= bus.spi_data;
  end

  assign bus.sample        = r_sample;
  assign bus.rd_data       = r_mem[r_rptr];
  assign bus.rd_valid      = !w_empty;
  assign bus.full          = w_full;
  assign bus.empty         = w_empty;
  assign bus.count         = r_count;
  assign bus.overflow      = r_overflow;
  assign bus.missed_sample = r_missed;
endmodule

// File: tb/tb_mic_sample_fifo.sv
// Bench for mic_sample_fifo: directed scenarios plus random traffic, every cycle
// compared against a queue-based reference model.
module tb_mic_sample_fifo;
  localparam int DEPTH = 4;
  localparam int SDIV  = 8;

  logic sysclk;
  logic PRESETn;

  mic_sample_fifo_if #(.DEPTH(DEPTH)) bus ();

  mic_sample_fifo #(.DEPTH(DEPTH), .SAMPLE_DIV(SDIV)) dut (
    .sysclk  (sysclk),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [15:0] m_q[$];
  int          m_en_cyc;
  bit          m_csb_prev;
  bit          m_sample;
  bit          m_ovf;
  bit          m_miss;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_en_cyc   = 0;
    m_csb_prev = 1'b1;
    m_sample   = 1'b0;
    m_ovf      = 1'b0;
    m_miss     = 1'b0;
  endtask

  task automatic compare_all();
    chk("sample",   bus.sample,        m_sample);
    chk("count",    bus.count,         m_q.size());
    chk("empty",    bus.empty,         m_q.size() == 0);
    chk("full",     bus.full,          m_q.size() == DEPTH);
    chk("rd_valid", bus.rd_valid,      m_q.size() != 0);
    chk("overflow", bus.overflow,      m_ovf);
    chk("missed",   bus.missed_sample, m_miss);
    if (m_q.size() != 0) chk("rd_data", bus.rd_data, m_q[0]);
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input bit en, input bit clr, input bit csb, input logic [15:0] d, input bit rd);
    bit tick, wr, pop;
    @(negedge sysclk);
    bus.enable   = en;
    bus.clear    = clr;
    bus.cs_b     = csb;
    bus.spi_data = d;
    bus.rd_en    = rd;
    tick       = en && ((m_en_cyc % SDIV) == SDIV - 1);
    m_en_cyc   = en ? m_en_cyc + 1 : 0;
    m_sample   = tick && csb;
    wr         = csb && !m_csb_prev;
    m_csb_prev = csb;
    if (clr) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_miss = 1'b0;
    end else begin
      pop = rd && (m_q.size() != 0);
      if (tick && !csb) m_miss = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (wr) begin
        if (m_q.size() < DEPTH) m_q.push_back(d);
        else                    m_ovf = 1'b1;
      end
    end
    @(posedge sysclk);
    #1;
    compare_all();
  endtask

  task automatic frame(input logic [15:0] w, input bit rd_at_rise);
    repeat (3) step(1'b0, 1'b0, 1'b0, w, 1'b0);
    step(1'b0, 1'b0, 1'b1, w, rd_at_rise);
    repeat (2) step(1'b0, 1'b0, 1'b1, 16'($urandom), 1'b0);
  endtask

  task automatic pop_one();
    step(1'b0, 1'b0, 1'b1, 16'h0, 1'b1);
  endtask

  int pulses;
  bit r_en, r_cs;

  initial begin
    PRESETn      = 1'b0;
    bus.enable   = 1'b0;
    bus.clear    = 1'b0;
    bus.cs_b     = 1'b1;
    bus.spi_data = 16'h0;
    bus.rd_en    = 1'b0;
    model_reset();
    repeat (3) @(posedge sysclk);
    #1;
    compare_all();
    @(negedge sysclk);
    PRESETn = 1'b1;

    // strobe timing: pulses after cycles 8 and 16, none once enable drops at 20
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b1, 16'h0, 1'b0);
      if (bus.sample) pulses++;
      if (i == 7) chk("first_strobe", bus.sample, 1'b1);
      if (i == 8) chk("strobe_width", bus.sample, 1'b0);
    end
    chk("pulses_enabled", pulses, 2);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b1, 16'h0, 1'b0);
      if (bus.sample) pulses++;
    end
    chk("pulses_disabled", pulses, 0);

    // capture and read
    step(1'b0, 1'b0, 1'b1, 16'h0, 1'b1);
    frame(16'hA5C3, 1'b0);
    chk("cap_first", bus.rd_data, 16'hA5C3);
    chk("cap_cnt1", bus.count, 1);
    frame(16'h1234, 1'b0);
    chk("cap_cnt2", bus.count, 2);
    pop_one();
    chk("cap_second", bus.rd_data, 16'h1234);
    pop_one();
    chk("cap_empty", bus.empty, 1'b1);

    // overflow
    for (int i = 1; i <= 5; i++) begin
      frame(16'h1000 + 16'(i), 1'b0);
      if (i == 4) chk("ovf_full4", bus.full, 1'b1);
    end
    chk("ovf_flag", bus.overflow, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_order", bus.rd_data, 16'h1000 + 16'(i));
      pop_one();
    end

    // full with simultaneous pop
    step(1'b0, 1'b1, 1'b1, 16'h0, 1'b0);
    for (int i = 1; i <= 4; i++) frame(16'h2000 + 16'(i), 1'b0);
    frame(16'hBEEF, 1'b1);
    chk("fp_count", bus.count, 4);
    chk("fp_ovf", bus.overflow, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("fp_beef_last", bus.rd_data, 16'hBEEF);
      pop_one();
    end

    // missed sample, then clear (with a cs_b rise in the clear cycle)
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'h5555, 1'b0);
      if (bus.sample) pulses++;
    end
    chk("miss_no_pulse", pulses, 0);
    chk("miss_flag", bus.missed_sample, 1'b1);
    step(1'b0, 1'b1, 1'b1, 16'h5555, 1'b0);
    chk("clr_miss", bus.missed_sample, 1'b0);
    chk("clr_empty", bus.empty, 1'b1);
    chk("clr_count", bus.count, 0);

    // random traffic
    r_en = 1'b0;
    r_cs = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) r_en = !r_en;
      if ($urandom_range(0, 3) == 0)  r_cs = !r_cs;
      step(r_en, $urandom_range(0, 79) == 0, r_cs, 16'($urandom), $urandom_range(0, 2) == 0);
    end

    // reset mid-operation
    step(1'b0, 1'b1, 1'b1, 16'h0, 1'b0);
    for (int i = 1; i <= 3; i++) frame(16'h3000 + 16'(i), 1'b0);
    chk("rst_pre_count", bus.count, 3);
    repeat (2) step(1'b1, 1'b0, 1'b0, 16'h7777, 1'b0);
    @(negedge sysclk);
    #2;
    PRESETn    = 1'b0;
    bus.cs_b   = 1'b1;
    bus.enable = 1'b0;
    #1;
    chk("rst_async_count", bus.count, 0);
    chk("rst_async_empty", bus.empty, 1'b1);
    chk("rst_async_valid", bus.rd_valid, 1'b0);
    chk("rst_async_full", bus.full, 1'b0);
    chk("rst_async_sample", bus.sample, 1'b0);
    model_reset();
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    PRESETn = 1'b1;
    repeat (4) step(1'b0, 1'b0, 1'b1, 16'h9999, 1'b0);
    chk("rst_no_write", bus.count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
